// File: rtl/cdb_broadcaster_if.sv
// Bundle of issue, result, acknowledge and broadcast signals between the
// execution units and the CDB broadcaster.
interface cdb_broadcaster_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              issue_int;
    logic              issue_ls;
    logic              issue_mult;
    logic              issue_div;

    logic              int_valid;
    logic [TAG_W-1:0]  int_tag;
    logic [DATA_W-1:0] int_data;
    logic              ls_valid;
    logic [TAG_W-1:0]  ls_tag;
    logic [DATA_W-1:0] ls_data;
    logic              mult_valid;
    logic [TAG_W-1:0]  mult_tag;
    logic [DATA_W-1:0] mult_data;
    logic              div_valid;
    logic [TAG_W-1:0]  div_tag;
    logic [DATA_W-1:0] div_data;

    logic              int_ack;
    logic              ls_ack;
    logic              mult_ack;
    logic              div_ack;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [6:0]        owner_status;
    logic              err_collision;
    logic              err_missing;
    logic              err_unexpected;

    modport master (
        output issue_int, issue_ls, issue_mult, issue_div,
        output int_valid, int_tag, int_data, ls_valid, ls_tag, ls_data,
        output mult_valid, mult_tag, mult_data, div_valid, div_tag, div_data,
        input  int_ack, ls_ack, mult_ack, div_ack,
        input  cdb_valid, cdb_tag, cdb_data, owner_status,
        input  err_collision, err_missing, err_unexpected
    );

    modport slave (
        input  issue_int, issue_ls, issue_mult, issue_div,
        input  int_valid, int_tag, int_data, ls_valid, ls_tag, ls_data,
        input  mult_valid, mult_tag, mult_data, div_valid, div_tag, div_data,
        output int_ack, ls_ack, mult_ack, div_ack,
        output cdb_valid, cdb_tag, cdb_data, owner_status,
        output err_collision, err_missing, err_unexpected
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// Mirrors the issue unit's CDB slot reservations with owner IDs, acks the
// owning FU's result when its slot matures and drives a registered broadcast.
module cdb_broadcaster #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input logic              clk,
    input logic              rst,
    cdb_broadcaster_if.slave bus
);
    localparam logic [2:0] OWN_NONE = 3'd0;
    localparam logic [2:0] OWN_INT  = 3'd1;
    localparam logic [2:0] OWN_LS   = 3'd2;
    localparam logic [2:0] OWN_MULT = 3'd3;
    localparam logic [2:0] OWN_DIV  = 3'd4;

    logic [6:0][2:0]   owner_q, owner_d;
    logic [2:0]        sel;
    logic              collision, missing, unexpected, sel_valid, ack_any;
    logic [TAG_W-1:0]  bc_tag;
    logic [DATA_W-1:0] bc_data;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic              err_collision_q, err_missing_q, err_unexpected_q;

    // Owner shift register; an existing owner always beats a new issue.
    always_comb begin
        owner_d[6] = bus.issue_div ? OWN_DIV : OWN_NONE;
        owner_d[5] = owner_q[6];
        owner_d[4] = owner_q[5];
        owner_d[3] = (bus.issue_mult && owner_q[4] == OWN_NONE) ? OWN_MULT : owner_q[4];
        owner_d[2] = owner_q[3];
        owner_d[1] = owner_q[2];
        if (owner_q[1] == OWN_NONE && bus.issue_int) begin
            owner_d[0] = OWN_INT;
        end else if (owner_q[1] == OWN_NONE && bus.issue_ls) begin
            owner_d[0] = OWN_LS;
        end else begin
            owner_d[0] = owner_q[1];
        end
        collision = (bus.issue_mult && owner_q[4] != OWN_NONE)
                 || ((bus.issue_int || bus.issue_ls) && owner_q[1] != OWN_NONE)
                 || (bus.issue_int && bus.issue_ls);
    end

    assign sel = owner_q[0];

    always_comb begin
        sel_valid = 1'b0;
        bc_tag    = bus.int_tag;
        bc_data   = bus.int_data;
        case (sel)
            OWN_INT:  sel_valid = bus.int_valid;
            OWN_LS: begin
                sel_valid = bus.ls_valid;
                bc_tag    = bus.ls_tag;
                bc_data   = bus.ls_data;
            end
            OWN_MULT: begin
                sel_valid = bus.mult_valid;
                bc_tag    = bus.mult_tag;
                bc_data   = bus.mult_data;
            end
            OWN_DIV: begin
                sel_valid = bus.div_valid;
                bc_tag    = bus.div_tag;
                bc_data   = bus.div_data;
            end
            default: sel_valid = 1'b0;
        endcase
        ack_any    = (sel != OWN_NONE) && sel_valid;
        missing    = (sel != OWN_NONE) && !sel_valid;
        unexpected = (bus.int_valid && sel != OWN_INT) || (bus.ls_valid && sel != OWN_LS)
                  || (bus.mult_valid && sel != OWN_MULT) || (bus.div_valid && sel != OWN_DIV);
    end

    assign bus.int_ack  = (sel == OWN_INT)  && bus.int_valid;
    assign bus.ls_ack   = (sel == OWN_LS)   && bus.ls_valid;
    assign bus.mult_ack = (sel == OWN_MULT) && bus.mult_valid;
    assign bus.div_ack  = (sel == OWN_DIV)  && bus.div_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q          <= '0;
            cdb_valid_q      <= 1'b0;
            cdb_tag_q        <= '0;
            cdb_data_q       <= '0;
            err_collision_q  <= 1'b0;
            err_missing_q    <= 1'b0;
            err_unexpected_q <= 1'b0;
        end else begin
            owner_q          <= owner_d;
            cdb_valid_q      <= ack_any;
            if (ack_any) begin
                cdb_tag_q  <= bc_tag;
                cdb_data_q <= bc_data;
            end
            err_collision_q  <= collision;
            err_missing_q    <= missing;
            err_unexpected_q <= unexpected;
        end
    end

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            bus.owner_status[i] = (owner_q[i] != OWN_NONE);
        end
    end

    assign bus.cdb_valid      = cdb_valid_q;
    assign bus.cdb_tag        = cdb_tag_q;
    assign bus.cdb_data       = cdb_data_q;
    assign bus.err_collision  = err_collision_q;
    assign bus.err_missing    = err_missing_q;
    assign bus.err_unexpected = err_unexpected_q;
endmodule
